// File: rtl/parking_gate_scheduler_pkg.sv
// Shared types and default parameters for the parking gate scheduler.
// Optional gate-0 priority is selected with `PARK_GATE0_PRIORITY_EN (see the top module).
package parking_pkg;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    OPEN = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  localparam int DEF_N_GATES        = 4;
  localparam int DEF_CAPACITY       = 12;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int DEF_GAP_CYCLES     = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/parking_gate_scheduler_if.sv
// Gate-side bundle of the parking gate scheduler: requests and sensor pulses in, grants and status out.
// master drives requests and sensors, slave is the scheduler.
interface parking_gate_scheduler_if
  import parking_pkg::*;
#(
  parameter int N_GATES = DEF_N_GATES,
  parameter int CNT_W   = $clog2(DEF_CAPACITY + 1)
);

  // Handshake: entry_req[i] is a level held until grant[i] rises; grant is one-hot
  // and stays high until entry_pass[i] pulses or the barrier times out.
  logic [N_GATES-1:0] entry_req;
  logic [N_GATES-1:0] entry_pass;
  logic               exit_pulse;
  logic [N_GATES-1:0] grant;
  logic               barrier_open;
  logic [CNT_W-1:0]   car_count;
  logic               full;
  logic               timeout_err;
  sched_state_t       state;

  modport master (
    output entry_req, entry_pass, exit_pulse,
    input  grant, barrier_open, car_count, full, timeout_err, state
  );

  modport slave (
    input  entry_req, entry_pass, exit_pulse,
    output grant, barrier_open, car_count, full, timeout_err, state
  );

endinterface

// File: rtl/parking_gate_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// Any gate-0 override is applied by the parent before/after this block.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  always_comb begin
    logic         found;
    int           j;
    logic [W-1:0] j_idx;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    j_idx = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      j_idx = W'(j);
      if (!found && req[j_idx]) begin
        found      = 1'b1;
        gnt[j_idx] = 1'b1;
        idx        = j_idx;
      end
    end
  end

endmodule

// File: rtl/parking_gate_scheduler.sv
// Round-robin entry-gate scheduler with barrier timeout and occupancy tracking.
// Define PARK_GATE0_PRIORITY_EN to let gate 0 pre-empt the round-robin order.
module parking_gate_scheduler
  import parking_pkg::*;
#(
  parameter int N_GATES        = DEF_N_GATES,
  parameter int CAPACITY       = DEF_CAPACITY,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  parking_gate_scheduler_if.slave bus
);

  localparam int CNT_W = $clog2(CAPACITY + 1);
  localparam int IDX_W = $clog2(N_GATES);
  localparam int TMR_W = $clog2(max_int(TIMEOUT_CYCLES, GAP_CYCLES)) + 1;

  sched_state_t       state_q, state_d;
  logic [N_GATES-1:0] grant_q, grant_d;
  logic               barrier_q, barrier_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic [N_GATES-1:0] arb_req;
  logic [N_GATES-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   arb_idx_next;
  logic               pass_hit;
  logic               inc;
  logic               dec;

`ifdef PARK_GATE0_PRIORITY_EN
  // Gate 0 is served by the override, so round-robin only sees gates 1..N-1.
  assign arb_req = bus.entry_req & ~N_GATES'(1);
`else
  assign arb_req = bus.entry_req;
`endif

  rr_arbiter #(.N(N_GATES), .W(IDX_W)) u_arb (
    .req (arb_req),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign arb_idx_next = (arb_idx == IDX_W'(N_GATES - 1)) ? '0 : arb_idx + 1'b1;

  // Only the granted gate's back sensor closes the barrier.
  assign pass_hit = |(bus.entry_pass & grant_q);

  always_comb begin
    state_d   = state_q;
    grant_d   = '0;
    barrier_d = 1'b0;
    timeout_d = 1'b0;
    rr_ptr_d  = rr_ptr_q;
    timer_d   = timer_q;
    case (state_q)
      ARB: begin
        timer_d = '0;
        if (|bus.entry_req && !full_q) begin
`ifdef PARK_GATE0_PRIORITY_EN
          if (bus.entry_req[0]) begin
            grant_d = N_GATES'(1);
          end else begin
            grant_d  = arb_gnt;
            rr_ptr_d = arb_idx_next;
          end
`else
          grant_d  = arb_gnt;
          rr_ptr_d = arb_idx_next;
`endif
          barrier_d = 1'b1;
          state_d   = OPEN;
        end
      end
      OPEN: begin
        grant_d   = grant_q;
        barrier_d = 1'b1;
        timer_d   = timer_q + 1'b1;
        if (pass_hit) begin
          grant_d   = '0;
          barrier_d = 1'b0;
          timer_d   = '0;
          state_d   = GAP;
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          grant_d   = '0;
          barrier_d = 1'b0;
          timeout_d = 1'b1;
          timer_d   = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TMR_W'(GAP_CYCLES - 1)) begin
          timer_d = '0;
          state_d = ARB;
        end
      end
      default: begin
        timer_d = '0;
        state_d = ARB;
      end
    endcase
  end

  // A pass and an exit in the same cycle cancel; both ends of the range saturate.
  always_comb begin
    inc     = (state_q == OPEN) && pass_hit;
    dec     = bus.exit_pulse;
    count_d = count_q;
    if (inc && !dec) begin
      if (count_q < CNT_W'(CAPACITY)) count_d = count_q + 1'b1;
    end else if (dec && !inc) begin
      if (count_q != '0) count_d = count_q - 1'b1;
    end
    full_d = (count_d == CNT_W'(CAPACITY));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB;
      grant_q   <= '0;
      barrier_q <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
      full_q    <= 1'b0;
      rr_ptr_q  <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      barrier_q <= barrier_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
      full_q    <= full_d;
      rr_ptr_q  <= rr_ptr_d;
      timer_q   <= timer_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.barrier_open = barrier_q;
  assign bus.timeout_err  = timeout_q;
  assign bus.car_count    = count_q;
  assign bus.full         = full_q;
  assign bus.state        = state_q;

endmodule
